// File: rtl/gfx_pixel_writer.sv
// gfx_pixel_writer
// Render stage after the per-pixel blender: turns one pixel (x, y, colour)
// into one line-aligned memory write request with byte enables, and returns
// a one-cycle ack_o to the blender once the writer has completed.
// Optional feature: define GFX_PIXEL_WRITER_COMBINE_EN to add a one-line
// write-combining buffer in front of the writer.
module gfx_pixel_writer #(
    parameter int point_width = 16,
    parameter int MDW         = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            target_base_i,
    input  logic [point_width-1:0] target_size_x_i,
    input  logic [5:0]             bpp_i,
    input  logic [point_width-1:0] pixel_x_i,
    input  logic [point_width-1:0] pixel_y_i,
    input  logic [31:0]            pixel_color_i,
    input  logic                   strip_i,
    input  logic [MDW-1:0]         strip_color_i,
    input  logic                   write_i,
    output logic                   ack_o,
    input  logic                   wbm_busy_i,
    output logic [31:0]            render_addr_o,
    output logic [MDW-1:0]         render_data_o,
    output logic [MDW/8-1:0]       render_sel_o,
    output logic                   render_request_o,
    input  logic                   render_ack_i
);
    localparam int SELW = MDW / 8;
    localparam int LW   = $clog2(MDW);   // bit-offset width inside a line
    localparam int BW   = $clog2(SELW);  // byte-offset width inside a line

    typedef enum logic [2:0] { IDLE, CALC, CALC2, REQ, DONE } state_t;
    state_t state, next_state;

    // log2 of the pixel depth; bit 3 flags an unsupported depth.
    function automatic logic [3:0] bpp_log2(input logic [5:0] bpp);
        case (bpp)
            6'd1:    return 4'd0;
            6'd2:    return 4'd1;
            6'd4:    return 4'd2;
            6'd8:    return 4'd3;
            6'd16:   return 4'd4;
            6'd32:   return 4'd5;
            default: return 4'b1000;
        endcase
    endfunction

    logic [3:0]             bpp_lg_in;
    logic [31:0]            base_q;
    logic [point_width-1:0] x_q, y_q, size_x_q;
    logic [31:0]            color_q;
    logic [2:0]             lg_q;
    logic                   strip_q;
    logic [MDW-1:0]         strip_color_q;
    logic [31:0]            idx_q;

    logic [31:0]     bitpos, pix_addr, pix_mask;
    logic [LW-1:0]   mb;
    logic [3:0]      nbyte_mask;
    logic [MDW-1:0]  pix_data;
    logic [SELW-1:0] pix_sel;

    assign bpp_lg_in = bpp_log2(bpp_i);

`ifdef GFX_PIXEL_WRITER_COMBINE_EN
    logic            buf_valid;
    logic [31:0]     buf_addr;
    logic [MDW-1:0]  buf_data;
    logic [SELW-1:0] buf_sel;
    logic [MDW-1:0]  pix_bits;
    logic [5:0]      idle_cnt;
    logic            flush_q, ret_pixel_q;
    logic            buf_hit, need_flush, idle_flush;

    assign buf_hit    = buf_valid && !strip_q && (pix_addr == buf_addr);
    assign need_flush = buf_valid && !buf_hit;
    assign idle_flush = buf_valid && !write_i && (idle_cnt == 6'd63);
    assign pix_bits   = MDW'(pix_mask) << mb;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    // NOTE: next_state gets a default before the case so that no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (write_i) next_state = bpp_lg_in[3] ? DONE : CALC;
`ifdef GFX_PIXEL_WRITER_COMBINE_EN
                else if (idle_flush) next_state = REQ;
`endif
            end
            CALC:  next_state = CALC2;
`ifdef GFX_PIXEL_WRITER_COMBINE_EN
            CALC2: next_state = (need_flush || strip_q) ? REQ : DONE;
            REQ: begin
                if (render_ack_i) begin
                    if (!flush_q)         next_state = DONE;
                    else if (ret_pixel_q) next_state = CALC2;
                    else                  next_state = IDLE;
                end
            end
`else
            CALC2: next_state = REQ;
            REQ:   if (render_ack_i) next_state = DONE;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the pixel on acceptance, then form the linear pixel index.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            size_x_q      <= '0;
            color_q       <= '0;
            lg_q          <= '0;
            strip_q       <= 1'b0;
            strip_color_q <= '0;
            idx_q         <= '0;
        end else begin
            if (state == IDLE && write_i) begin
                base_q        <= target_base_i;
                x_q           <= pixel_x_i;
                y_q           <= pixel_y_i;
                size_x_q      <= target_size_x_i;
                color_q       <= pixel_color_i;
                lg_q          <= bpp_lg_in[2:0];
                strip_q       <= strip_i;
                strip_color_q <= strip_color_i;
            end
            if (state == CALC) idx_q <= 32'(y_q) * 32'(size_x_q) + 32'(x_q);
        end
    end

    // Line address, bit offset and lane placement of the captured pixel.
    always_comb begin
        bitpos     = idx_q << lg_q;
        mb         = bitpos[LW-1:0];
        pix_addr   = base_q + ((bitpos >> LW) << BW);
        pix_mask   = 32'hFFFF_FFFF >> (6'd32 - (6'd1 << lg_q));
        nbyte_mask = 4'h1;
        if (lg_q == 3'd5)      nbyte_mask = 4'hF;
        else if (lg_q == 3'd4) nbyte_mask = 4'h3;
        pix_data   = MDW'(color_q & pix_mask) << mb;
        pix_sel    = SELW'(nbyte_mask) << mb[LW-1:3];
        if (strip_q) begin
            pix_data = strip_color_q;
            pix_sel  = '1;
        end
    end

    // Handshake outputs and the write payload presented to the writer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o            <= 1'b0;
            render_request_o <= 1'b0;
            render_addr_o    <= '0;
            render_data_o    <= '0;
            render_sel_o     <= '0;
        end else begin
            ack_o <= (next_state == DONE);
            if (state == REQ)
                render_request_o <= !render_ack_i && (render_request_o || !wbm_busy_i);
            else
                render_request_o <= (next_state == REQ) && !wbm_busy_i;
            if (next_state == REQ && state != REQ) begin
`ifdef GFX_PIXEL_WRITER_COMBINE_EN
                if (state == IDLE || need_flush) begin
                    render_addr_o <= buf_addr;
                    render_data_o <= buf_data;
                    render_sel_o  <= buf_sel;
                end else begin
                    render_addr_o <= pix_addr;
                    render_data_o <= pix_data;
                    render_sel_o  <= pix_sel;
                end
`else
                render_addr_o <= pix_addr;
                render_data_o <= pix_data;
                render_sel_o  <= pix_sel;
`endif
            end
        end
    end

`ifdef GFX_PIXEL_WRITER_COMBINE_EN
    // Combining-buffer control: validity, line tag, flush bookkeeping, idle timer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_valid   <= 1'b0;
            buf_addr    <= '0;
            idle_cnt    <= '0;
            flush_q     <= 1'b0;
            ret_pixel_q <= 1'b0;
        end else begin
            if (next_state == REQ && state != REQ) begin
                flush_q     <= (state == IDLE) || need_flush;
                ret_pixel_q <= (state == CALC2);
            end
            if (state == REQ && render_ack_i && flush_q) buf_valid <= 1'b0;
            if (state == CALC2 && next_state == DONE && !buf_hit) begin
                buf_valid <= 1'b1;
                buf_addr  <= pix_addr;
            end
            if (state == IDLE && buf_valid && !write_i) idle_cnt <= idle_cnt + 6'd1;
            else                                         idle_cnt <= '0;
        end
    end

    // Combining-buffer payload: load on a new line, merge on a hit.
    // NOTE: the payload has no reset; it is only ever read while buf_valid is
    // set, and buf_valid is cleared by reset.
    always_ff @(posedge clk_i) begin
        if (state == CALC2 && next_state == DONE) begin
            if (buf_hit) begin
                buf_data <= (buf_data & ~pix_bits) | pix_data;
                buf_sel  <= buf_sel | pix_sel;
            end else begin
                buf_data <= pix_data;
                buf_sel  <= pix_sel;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gfx_pixel_writer.sv
// Self-checking bench for gfx_pixel_writer (default build, no write combining).
// Directed scenarios plus randomized pixels checked against an arithmetic model.
module tb_gfx_pixel_writer;
    localparam int PW   = 16;
    localparam int MDW  = 256;
    localparam int SELW = MDW / 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [31:0]     target_base_i;
    logic [PW-1:0]   target_size_x_i;
    logic [5:0]      bpp_i;
    logic [PW-1:0]   pixel_x_i;
    logic [PW-1:0]   pixel_y_i;
    logic [31:0]     pixel_color_i;
    logic            strip_i;
    logic [MDW-1:0]  strip_color_i;
    logic            write_i;
    logic            ack_o;
    logic            wbm_busy_i;
    logic [31:0]     render_addr_o;
    logic [MDW-1:0]  render_data_o;
    logic [SELW-1:0] render_sel_o;
    logic            render_request_o;
    logic            render_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    gfx_pixel_writer #(.point_width(PW), .MDW(MDW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .target_base_i    (target_base_i),
        .target_size_x_i  (target_size_x_i),
        .bpp_i            (bpp_i),
        .pixel_x_i        (pixel_x_i),
        .pixel_y_i        (pixel_y_i),
        .pixel_color_i    (pixel_color_i),
        .strip_i          (strip_i),
        .strip_color_i    (strip_color_i),
        .write_i          (write_i),
        .ack_o            (ack_o),
        .wbm_busy_i       (wbm_busy_i),
        .render_addr_o    (render_addr_o),
        .render_data_o    (render_data_o),
        .render_sel_o     (render_sel_o),
        .render_request_o (render_request_o),
        .render_ack_i     (render_ack_i)
    );

    // Reference model: pixel index times depth gives the bit position; the
    // line, byte lanes and data follow by division and modulo.
    task automatic model(input logic [31:0] base, input logic [15:0] w, input int bpp,
                         input logic [15:0] x, input logic [15:0] y, input logic [31:0] color,
                         input logic strip, input logic [MDW-1:0] sc,
                         output logic [31:0] addr, output logic [MDW-1:0] data,
                         output logic [SELW-1:0] sel);
        logic [31:0] idx, bitpos;
        logic [63:0] c;
        int mb;
        idx    = {16'd0, y} * {16'd0, w} + {16'd0, x};
        bitpos = idx * 32'(bpp);
        addr   = base + (bitpos / 32'(MDW)) * 32'(SELW);
        mb     = int'(bitpos % 32'(MDW));
        c      = 64'(color) & ((64'd1 << bpp) - 64'd1);
        data   = MDW'(c) << mb;
        sel    = '0;
        for (int b = mb / 8; b <= (mb + bpp - 1) / 8; b++) sel[b] = 1'b1;
        if (strip) begin
            data = sc;
            sel  = '1;
        end
    endtask

    task automatic drive(input logic [31:0] base, input logic [15:0] w, input logic [5:0] bpp,
                         input logic [15:0] x, input logic [15:0] y, input logic [31:0] color,
                         input logic strip, input logic [MDW-1:0] sc);
        target_base_i   = base;
        target_size_x_i = w;
        bpp_i           = bpp;
        pixel_x_i       = x;
        pixel_y_i       = y;
        pixel_color_i   = color;
        strip_i         = strip;
        strip_color_i   = sc;
        write_i         = 1'b1;
    endtask

    // Cycles from write_i to render_request_o; busy is held for busy_cycles edges.
    task automatic wait_request(input int busy_cycles, output int lat);
        lat = 0;
        wbm_busy_i = (busy_cycles > 0);
        while (!render_request_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
            if (lat == busy_cycles) wbm_busy_i = 1'b0;
        end
    endtask

    // Hold the request for ack_delay cycles, ack it, expect exactly one ack_o.
    task automatic complete(input string name, input int ack_delay);
        for (int i = 0; i < ack_delay; i++) begin
            wbm_busy_i = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
            n_cmp++;
            if (render_request_o !== 1'b1) begin
                n_err++;
                $display("FAIL %s request hold: got %b want 1", name, render_request_o);
            end
        end
        wbm_busy_i   = 1'b0;
        render_ack_i = 1'b1;
        @(posedge clk_i); #1;
        render_ack_i = 1'b0;
        n_cmp++;
        if (ack_o !== 1'b1 || render_request_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack: got ack_o=%b request=%b want 1/0", name, ack_o, render_request_o);
        end
        write_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++;
        if (ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack width: got ack_o=%b want 0", name, ack_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++;
        if (ack_o !== 1'b0 || render_request_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset handshake: got ack=%b req=%b want 0/0", ack_o, render_request_o);
        end
        n_cmp++;
        if (render_addr_o !== 32'd0 || render_sel_o !== '0 || render_data_o !== '0) begin
            n_err++;
            $display("FAIL reset payload: got addr=%h sel=%h data=%h want 0", render_addr_o, render_sel_o, render_data_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        n_cmp++;
        if (ack_o !== 1'b0 || render_request_o !== 1'b0) begin
            n_err++;
            $display("FAIL post-reset idle: got ack=%b req=%b want 0/0", ack_o, render_request_o);
        end
    endtask

    task automatic test_pixel_write();
        int lat;
        drive(32'h1000, 16'd640, 6'd16, 16'd3, 16'd1, 32'h0000_ABCD, 1'b0, '0);
        wait_request(0, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL pixel latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (render_addr_o !== 32'h1500) begin
            n_err++;
            $display("FAIL pixel addr: got %h want 00001500", render_addr_o);
        end
        n_cmp++;
        if (render_data_o !== (MDW'(32'hABCD) << 48)) begin
            n_err++;
            $display("FAIL pixel data: got %h", render_data_o);
        end
        n_cmp++;
        if (render_sel_o !== 32'h0000_00C0) begin
            n_err++;
            $display("FAIL pixel sel: got %h want 000000c0", render_sel_o);
        end
        complete("pixel", 0);
    endtask

    task automatic test_busy_holdoff();
        logic [31:0] ea;
        logic [MDW-1:0] ed;
        logic [SELW-1:0] es;
        logic stayed_low;
        model(32'h0004_0000, 16'd100, 32, 16'd5, 16'd7, 32'hDEAD_BEEF, 1'b0, '0, ea, ed, es);
        drive(32'h0004_0000, 16'd100, 6'd32, 16'd5, 16'd7, 32'hDEAD_BEEF, 1'b0, '0);
        wbm_busy_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i); #1;
        end
        stayed_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            if (render_request_o !== 1'b0) stayed_low = 1'b0;
        end
        n_cmp++;
        if (stayed_low !== 1'b1) begin
            n_err++;
            $display("FAIL busy holdoff: request rose while busy");
        end
        wbm_busy_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++;
        if (render_request_o !== 1'b1) begin
            n_err++;
            $display("FAIL busy release: got request=%b want 1", render_request_o);
        end
        n_cmp++;
        if (render_addr_o !== ea || render_data_o !== ed || render_sel_o !== es) begin
            n_err++;
            $display("FAIL busy payload: got addr=%h sel=%h want addr=%h sel=%h", render_addr_o, render_sel_o, ea, es);
        end
        complete("busy", 3);
    endtask

    task automatic test_strip();
        int lat;
        logic [MDW-1:0] sc;
        sc = {SELW{8'h55}};
        drive(32'h0002_0000, 16'd64, 6'd8, 16'd0, 16'd2, 32'h0000_0012, 1'b1, sc);
        wait_request(0, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL strip latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (render_addr_o !== 32'h0002_0080) begin
            n_err++;
            $display("FAIL strip addr: got %h want 00020080", render_addr_o);
        end
        n_cmp++;
        if (render_sel_o !== {SELW{1'b1}} || render_data_o !== sc) begin
            n_err++;
            $display("FAIL strip payload: got sel=%h data=%h", render_sel_o, render_data_o);
        end
        complete("strip", 1);
    endtask

    task automatic test_illegal_bpp();
        logic req_seen;
        drive(32'h1000, 16'd640, 6'd24, 16'd1, 16'd1, 32'h1234_5678, 1'b0, '0);
        @(posedge clk_i); #1;
        n_cmp++;
        if (ack_o !== 1'b1 || render_request_o !== 1'b0) begin
            n_err++;
            $display("FAIL illegal bpp ack: got ack=%b req=%b want 1/0", ack_o, render_request_o);
        end
        write_i  = 1'b0;
        req_seen = 1'b0;
        repeat (4) begin
            @(posedge clk_i); #1;
            if (render_request_o !== 1'b0 || ack_o !== 1'b0) req_seen = 1'b1;
        end
        n_cmp++;
        if (req_seen !== 1'b0) begin
            n_err++;
            $display("FAIL illegal bpp quiet: got activity after ack want none");
        end
    endtask

    // render_ack_i outside REQ is ignored; write_i may drop once accepted.
    task automatic test_boundary();
        logic early_ack;
        drive(32'h0, 16'd16, 6'd4, 16'd40, 16'd3, 32'h0000_0009, 1'b0, '0);
        render_ack_i = 1'b1;
        early_ack    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            write_i = 1'b0;
            if (ack_o !== 1'b0) early_ack = 1'b1;
        end
        render_ack_i = 1'b0;
        n_cmp++;
        if (early_ack !== 1'b0 || render_request_o !== 1'b1) begin
            n_err++;
            $display("FAIL boundary: got early_ack=%b request=%b want 0/1", early_ack, render_request_o);
        end
        // idx = 3*16+40 = 88, bitpos = 352: line 1, mb = 96, byte 12
        n_cmp++;
        if (render_addr_o !== 32'h20 || render_sel_o !== 32'h0000_1000 || render_data_o !== (MDW'(9) << 96)) begin
            n_err++;
            $display("FAIL boundary payload: got addr=%h sel=%h want 00000020/00001000", render_addr_o, render_sel_o);
        end
        complete("boundary", 0);
    endtask

    task automatic test_reset_in_req();
        int lat;
        logic spurious;
        drive(32'h8000, 16'd32, 6'd8, 16'd1, 16'd1, 32'h0000_00AA, 1'b0, '0);
        wait_request(0, lat);
        #3;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (render_request_o !== 1'b0 || render_addr_o !== 32'd0) begin
            n_err++;
            $display("FAIL async reset: got req=%b addr=%h want 0/0", render_request_o, render_addr_o);
        end
        write_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i    = 1'b1;
        spurious = 1'b0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (ack_o !== 1'b0 || render_request_o !== 1'b0) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious !== 1'b0) begin
            n_err++;
            $display("FAIL reset in REQ: got ack or request after reset");
        end
        drive(32'h8000, 16'd32, 6'd8, 16'd1, 16'd1, 32'h0000_00AA, 1'b0, '0);
        wait_request(0, lat);
        n_cmp++;
        if (lat !== 3 || render_addr_o !== 32'h8020) begin
            n_err++;
            $display("FAIL after reset: got lat=%0d addr=%h want 3/00008020", lat, render_addr_o);
        end
        complete("after_reset", 0);
    endtask

    task automatic test_random();
        int bpp_tab[6] = '{1, 2, 4, 8, 16, 32};
        for (int n = 0; n < 40; n++) begin
            int bpp, k, lat, exp_lat;
            logic [31:0] base, color, ea;
            logic [15:0] w, x, y;
            logic strip;
            logic [MDW-1:0] sc, ed;
            logic [SELW-1:0] es;
            bpp   = bpp_tab[$urandom_range(0, 5)];
            base  = $urandom;
            w     = (n % 2 == 0) ? 16'($urandom_range(1, 1024)) : 16'($urandom);
            x     = 16'($urandom);
            y     = (n % 2 == 0) ? 16'($urandom_range(0, 600)) : 16'($urandom);
            color = $urandom;
            strip = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < MDW / 32; i++) sc[i*32 +: 32] = $urandom;
            k     = $urandom_range(0, 5);
            exp_lat = (k + 1 > 3) ? k + 1 : 3;
            model(base, w, bpp, x, y, color, strip, sc, ea, ed, es);
            drive(base, w, 6'(bpp), x, y, color, strip, sc);
            wait_request(k, lat);
            n_cmp++;
            if (lat !== exp_lat) begin
                n_err++;
                $display("FAIL random[%0d] latency: got %0d want %0d", n, lat, exp_lat);
            end
            n_cmp++;
            if (render_addr_o !== ea || render_sel_o !== es) begin
                n_err++;
                $display("FAIL random[%0d] addr/sel: got %h/%h want %h/%h (bpp %0d)", n, render_addr_o, render_sel_o, ea, es, bpp);
            end
            n_cmp++;
            if (render_data_o !== ed) begin
                n_err++;
                $display("FAIL random[%0d] data: got %h want %h", n, render_data_o, ed);
            end
            complete("random", $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        target_base_i   = '0;
        target_size_x_i = '0;
        bpp_i           = 6'd8;
        pixel_x_i       = '0;
        pixel_y_i       = '0;
        pixel_color_i   = '0;
        strip_i         = 1'b0;
        strip_color_i   = '0;
        write_i         = 1'b0;
        wbm_busy_i      = 1'b0;
        render_ack_i    = 1'b0;
        test_reset();
        test_pixel_write();
        test_busy_holdoff();
        test_strip();
        test_illegal_bpp();
        test_boundary();
        test_reset_in_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gfx_pixel_writer.md
Name: gfx_pixel_writer

Overview:
- Render stage that sits directly downstream of the per-pixel blender.
- Accepts one pixel per handshake: x, y, 32-bit colour, write strobe, strip flag and a pre-replicated strip word.
- Computes the target memory line address and byte-lane select, and places the colour on its bit lane within an MDW-wide line.
- Issues one write request to the wishbone master (writer) and returns ack_o to the blender once the memory ack arrives.

Parameters:
- point_width, 16, coordinate width.
- MDW, 256, memory data width in bits; a power of two, 32..256.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- target_base_i  in  32  byte base address of the target surface.
- target_size_x_i  in  point_width  surface width in pixels.
- bpp_i  in  6  bits per pixel; legal values 1,2,4,8,16,32.
- pixel_x_i  in  point_width  pixel x.
- pixel_y_i  in  point_width  pixel y.
- pixel_color_i  in  32  pixel colour, LSB-aligned.
- strip_i  in  1  write the whole line with strip_color_i.
- strip_color_i  in  MDW  replicated strip data.
- write_i  in  1  pixel valid; held until ack_o.
- ack_o  out  1  one-cycle completion pulse to upstream.
- wbm_busy_i  in  1  writer busy; suppresses new requests.
- render_addr_o  out  32  line-aligned byte address.
- render_data_o  out  MDW  write data.
- render_sel_o  out  MDW/8  byte enables.
- render_request_o  out  1  write request.
- render_ack_i  in  1  writer completion.

Behaviour:
- Reset (rst_i low, asynchronous) sets:
  - state=IDLE
  - ack_o=0, render_request_o=0
  - render_addr_o=0, render_data_o=0, render_sel_o=0
- Address arithmetic:
  - idx = y*target_size_x_i + x, 32-bit unsigned.
  - bitpos = idx << log2(bpp_i).
  - line = bitpos >> log2(MDW).
  - render_addr_o = target_base_i + line*(MDW/8); the low log2(MDW/8) bits are always 0.
  - mb = bitpos mod MDW.
  - All products are truncated to 32 bits, with no overflow detection.
- Data lane placement:
  - render_data_o = (pixel_color_i & ((1<<bpp)-1)) << mb; all other bits are 0.
  - render_sel_o sets bytes floor(mb/8) .. floor((mb+bpp-1)/8).
  - For bpp<8 the whole containing byte is enabled. The writer is a read-modify-write path for sub-byte depths and is outside this block.
- Strip mode: render_data_o = strip_color_i and render_sel_o = all ones; the address is computed as above.
- State machine:
  - IDLE: when write_i=1, register inputs and go to CALC. An illegal bpp_i goes straight to DONE with no memory write.
  - CALC: one cycle for the registered multiply. Go to CALC2 (shift and lane placement, registered).
  - CALC2 → REQ.
  - REQ: render_request_o = !wbm_busy_i | render_request_o, i.e. it rises once the writer is not busy and then stays high. When render_ack_i=1, drop the request and go to DONE.
  - DONE: ack_o=1 for exactly one cycle, then IDLE. Upstream may present the next pixel in the cycle after the ack_o pulse.
- Latency: write_i to render_request_o is 3 cycles minimum. render_ack_i to ack_o is 1 cycle.
- Boundary conditions:
  - render_ack_i in any state other than REQ is ignored.
  - A deasserted write_i during CALC/CALC2/REQ is ignored; the transaction completes.
  - Reset mid-transaction drops the request immediately, and no ack_o is produced.
  - x/y beyond the surface is not clipped; the address is computed as-is.

Optional Feature:
- Macro GFX_PIXEL_WRITER_COMBINE_EN.
- When defined, a one-line write-combining buffer is present:
  - A pixel whose line address equals the buffered line merges its data and sel into the buffer (OR of sel, lane overwrite of data).
  - ack_o is issued 1 cycle after CALC2 with no memory write.
- The buffer is flushed (REQ with the buffered data/sel) on any of:
  - a pixel to a different line (flush first, then the new pixel is buffered);
  - a strip pixel (flush, then a normal strip write);
  - 64 idle cycles with valid data, counted by an internal 6-bit counter.
- Reset invalidates the buffer without writing.
- When the macro is undefined, every pixel produces exactly one write as described above, and no buffer or counter exists.

Test Plan:
- Pixel write: MDW=256, base=0x1000, width=640, bpp=16, x=3, y=1, colour=0xABCD. Required: addr=0x1000+(643*16>>8)*32=0x1500, mb=48, data[63:48]=0xABCD, sel=0x000000C0, and ack_o one cycle after render_ack_i.
- Busy hold-off: wbm_busy_i=1 for 10 cycles after CALC2. Required: render_request_o stays 0, then rises the cycle after busy drops and holds until ack.
- Strip write: strip_i=1, strip_color=all 0x55, bpp=8, x=0, y=2, width=64. Required: addr=base+128, sel all ones, data = strip word.
- Illegal bpp_i=24: required ack_o pulse and no render_request_o.
- Reset asserted while in REQ: required render_request_o=0 asynchronously, state=IDLE, and no ack_o.
- With GFX_PIXEL_WRITER_COMBINE_EN, four 32-bpp pixels at x=0..3, y=0, then x=8. Required: four ack_o with no writes, then one write with sel=0x0000FFFF and data holding the four colours, followed by buffering of x=8.
